// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-input / pipeline-control bundle between the MIPS datapath and pipe_hazard_ctrl.
// The master drives the decoded hazard fields, and the slave (the sequencer) returns latch controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       fd_rs;
  logic [4:0]       fd_rt;
  logic             fd_uses_rs;
  logic             fd_uses_rt;
  logic             dx_is_load;
  logic [4:0]       dx_rd;
  logic             dx_is_md;
  logic             md_is_div;
  logic             branch_taken;

  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             xm_en;
  logic             mw_en;
  logic             fd_flush;
  logic             dx_flush;
  logic             xm_flush;
  logic             md_start;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, dx_is_load, dx_rd,
           dx_is_md, md_is_div, branch_taken,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_busy, stall_cycles
  );

  modport slave (
    input  fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, dx_is_load, dx_rd,
           dx_is_md, md_is_div, branch_taken,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, taken-branch flushes,
// multicycle mult/div freezes and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 32,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               clr,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [1:0]         o_dbg_state
);

  localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CTR_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CTR_W-1:0] r_ctr;
  logic [CTR_W-1:0] w_ctr_nxt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_load_use;
  logic w_pc_en, w_fd_en, w_dx_en, w_xm_en, w_mw_en;
  logic w_fd_flush, w_dx_flush, w_xm_flush;
  logic w_md_start, w_md_busy;

  // r0 is never a real producer, so a load into r0 cannot create a dependency.
  assign w_load_use = bus.dx_is_load && (bus.dx_rd != 5'd0) &&
                      ((bus.fd_uses_rs && (bus.fd_rs == bus.dx_rd)) ||
                       (bus.fd_uses_rt && (bus.fd_rt == bus.dx_rd)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_RUN;
      r_ctr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctr   <= w_ctr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    case (r_state)
      ST_RUN: begin
        if (bus.dx_is_md) begin
          w_state_nxt = ST_MD_BUSY;
          w_ctr_nxt   = bus.md_is_div ? CTR_W'(DIV_LAT - 1) : CTR_W'(MULT_LAT - 1);
        end
      end
      ST_MD_BUSY: begin
        if (r_ctr == CTR_W'(1)) begin
          w_state_nxt = ST_MD_DONE;
          w_ctr_nxt   = '0;
        end else begin
          w_ctr_nxt = r_ctr - CTR_W'(1);
        end
      end
      ST_MD_DONE: w_state_nxt = ST_RUN;
      default: begin
        w_state_nxt = ST_RUN;
        w_ctr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_pc_en    = 1'b0;
    w_fd_en    = 1'b0;
    w_dx_en    = 1'b0;
    w_xm_en    = 1'b0;
    w_mw_en    = 1'b0;
    w_fd_flush = 1'b0;
    w_dx_flush = 1'b0;
    w_xm_flush = 1'b0;
    w_md_start = 1'b0;
    w_md_busy  = 1'b0;
    if (!clr) begin
      w_pc_en = 1'b1;
      w_fd_en = 1'b1;
      w_dx_en = 1'b1;
      w_xm_en = 1'b1;
      w_mw_en = 1'b1;
      case (r_state)
        ST_RUN: begin
          if (bus.dx_is_md) begin
            w_md_start = 1'b1;
            w_md_busy  = 1'b1;
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_dx_en    = 1'b0;
            w_xm_flush = 1'b1;
          end else if (bus.branch_taken) begin
            w_fd_flush = 1'b1;
            w_dx_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_dx_flush = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          // X/M keeps taking bubbles while M/W drains the older instructions.
          w_md_busy  = 1'b1;
          w_pc_en    = 1'b0;
          w_fd_en    = 1'b0;
          w_dx_en    = 1'b0;
          w_xm_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.fd_en        = w_fd_en;
  assign bus.dx_en        = w_dx_en;
  assign bus.xm_en        = w_xm_en;
  assign bus.mw_en        = w_mw_en;
  assign bus.fd_flush     = w_fd_flush;
  assign bus.dx_flush     = w_dx_flush;
  assign bus.xm_flush     = w_xm_flush;
  assign bus.md_start     = w_md_start;
  assign bus.md_busy      = w_md_busy;
  assign bus.stall_cycles = r_stall_cycles;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset/idle, load-use, branch priority,
// mult/div freeze timing and reset during a multicycle operation.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start, md_busy}
  localparam logic [9:0] CTL_OFF    = 10'b00000_000_00;
  localparam logic [9:0] CTL_IDLE   = 10'b11111_000_00;
  localparam logic [9:0] CTL_LDUSE  = 10'b00111_010_00;
  localparam logic [9:0] CTL_BRANCH = 10'b11111_110_00;
  localparam logic [9:0] CTL_START  = 10'b00011_001_11;
  localparam logic [9:0] CTL_BUSY   = 10'b00011_001_01;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_start = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MULT_LAT(32), .DIV_LAT(33), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!clr && bus.md_start) n_start++;

  function automatic logic [9:0] ctl();
    return {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
            bus.fd_flush, bus.dx_flush, bus.xm_flush, bus.md_start, bus.md_busy};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fd_rs        = 5'd0;
    bus.fd_rt        = 5'd0;
    bus.fd_uses_rs   = 1'b0;
    bus.fd_uses_rt   = 1'b0;
    bus.dx_is_load   = 1'b0;
    bus.dx_rd        = 5'd0;
    bus.dx_is_md     = 1'b0;
    bus.md_is_div    = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    clr = 1'b1;
    #1;
    check("clr_ctl", ctl(), CTL_OFF);
    tick();
    check("clr_state", dbg_state, 2'd0);
    check("clr_stall", bus.stall_cycles, 0);
    clr = 1'b0;
    #1;
  endtask

  task automatic load_use(input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rs, input logic use_rt, input logic [4:0] rd);
    bus.fd_rs      = rs;
    bus.fd_rt      = rt;
    bus.fd_uses_rs = use_rs;
    bus.fd_uses_rt = use_rt;
    bus.dx_is_load = 1'b1;
    bus.dx_rd      = rd;
    #1;
  endtask

  // Starts at RUN, ends one cycle after MD_DONE with dx_is_md still asserted.
  task automatic run_md(input int lat, input logic is_div, input int base, input string tag);
    bus.dx_is_md  = 1'b1;
    bus.md_is_div = is_div;
    #1;
    check({tag, "_start"}, ctl(), CTL_START);
    tick();
    for (int i = 1; i < lat; i++) begin
      check({tag, "_busy"}, ctl(), CTL_BUSY);
      tick();
    end
    check({tag, "_done_ctl"}, ctl(), CTL_IDLE);
    check({tag, "_done_state"}, dbg_state, 2'd2);
    check({tag, "_stall"}, bus.stall_cycles, base + lat);
    tick();
    check({tag, "_back_run"}, dbg_state, 2'd0);
  endtask

  initial begin
    clear_inputs();
    #2;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      check("idle_ctl", ctl(), CTL_IDLE);
      check("idle_stall", bus.stall_cycles, 0);
      tick();
    end

    // Load-use on rs: exactly one bubble.
    load_use(5'd5, 5'd9, 1'b1, 1'b0, 5'd5);
    check("lu_rs_ctl", ctl(), CTL_LDUSE);
    tick();
    clear_inputs();
    #1;
    check("lu_rs_after", ctl(), CTL_IDLE);
    check("lu_rs_stall", bus.stall_cycles, 1);

    // Load into r0 never stalls.
    load_use(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    check("lu_r0_ctl", ctl(), CTL_IDLE);
    tick();
    check("lu_r0_stall", bus.stall_cycles, 1);

    // Matching rs that the instruction does not read: no stall.
    load_use(5'd6, 5'd2, 1'b0, 1'b1, 5'd6);
    check("lu_unused_ctl", ctl(), CTL_IDLE);
    tick();

    // Load-use on rt.
    load_use(5'd1, 5'd7, 1'b1, 1'b1, 5'd7);
    check("lu_rt_ctl", ctl(), CTL_LDUSE);
    tick();
    check("lu_rt_stall", bus.stall_cycles, 2);
    clear_inputs();

    // Branch wins over a simultaneous load-use match.
    load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
    bus.branch_taken = 1'b1;
    #1;
    check("br_ctl", ctl(), CTL_BRANCH);
    tick();
    check("br_stall", bus.stall_cycles, 2);
    clear_inputs();
    #1;

    // Single mult.
    do_reset();
    n_start = 0;
    run_md(32, 1'b0, 0, "mult");
    clear_inputs();
    #1;
    check("mult_idle", ctl(), CTL_IDLE);
    tick();
    check("mult_starts", n_start, 1);

    // Div followed immediately by mult.
    do_reset();
    n_start = 0;
    run_md(33, 1'b1, 0, "div");
    run_md(32, 1'b0, 33, "div_mult");
    clear_inputs();
    #1;
    check("b2b_idle", ctl(), CTL_IDLE);
    tick();
    check("b2b_stall", bus.stall_cycles, 65);
    check("b2b_starts", n_start, 2);

    // clr asserted in cycle 10 of a mult.
    do_reset();
    bus.dx_is_md = 1'b1;
    #1;
    check("abort_start", ctl(), CTL_START);
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", bus.md_busy, 1'b1);
    check("abort_stall_before", bus.stall_cycles, 10);
    clr = 1'b1;
    #1;
    check("abort_busy_async", bus.md_busy, 1'b0);
    check("abort_ctl", ctl(), CTL_OFF);
    check("abort_state", dbg_state, 2'd0);
    check("abort_stall_clr", bus.stall_cycles, 0);
    tick();
    clr = 1'b0;
    clear_inputs();
    #1;
    check("abort_after_ctl", ctl(), CTL_IDLE);
    check("abort_after_state", dbg_state, 2'd0);
    tick();
    check("abort_after_stall", bus.stall_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Drives the enable and flush controls of the PC and the F/D, D/X, X/M and M/W pipeline latches, which are built from per-bit enable/clear flip-flops.
- Resolves three hazard classes:
  - load-use stalls
  - taken-branch flushes
  - multicycle mult/div freezes, timed by an internal latency counter
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, default 32: cycles the multiplier occupies the X stage; must be at least 2.
- DIV_LAT, default 33: cycles the divider occupies the X stage; must be at least 2.
- CNT_W, default 32: width of stall_cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- fd_rs  in  5  rs field of the instruction in F/D.
- fd_rt  in  5  rt field of the instruction in F/D.
- fd_uses_rs  in  1  F/D instruction reads rs.
- fd_uses_rt  in  1  F/D instruction reads rt.
- dx_is_load  in  1  the instruction in D/X is lw.
- dx_rd  in  5  destination register of the D/X instruction.
- dx_is_md  in  1  the instruction in D/X is mult or div.
- md_is_div  in  1  qualifies dx_is_md: 1 = div, 0 = mult.
- branch_taken  in  1  branch or jump resolved taken in X.
- pc_en  out  1  PC register enable.
- fd_en  out  1  F/D latch enable.
- dx_en  out  1  D/X latch enable.
- xm_en  out  1  X/M latch enable.
- mw_en  out  1  M/W latch enable.
- fd_flush  out  1  F/D latch synchronous clear (inserts a nop).
- dx_flush  out  1  D/X latch synchronous clear (inserts a nop).
- xm_flush  out  1  X/M latch synchronous clear (inserts a bubble).
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  high while the mult/div unit is running.
- stall_cycles  out  CNT_W  count of cycles in which pc_en was 0.

Behaviour:
- Registered state: state in {RUN, MD_BUSY, MD_DONE}, a latency counter sized to fit DIV_LAT, and stall_cycles. All control outputs are combinational from state and inputs.
- clr high (asynchronous): state=RUN, counter=0, stall_cycles=0.
- While clr is high, every enable, flush and md_start output is 0 and md_busy is 0.
- Default in RUN: all enables 1, all flushes 0, md_start 0, md_busy 0.
- RUN priority, highest first:
  1. Multicycle start: dx_is_md=1.
     - Outputs: md_start=1, pc_en=fd_en=dx_en=0, xm_flush=1, md_busy=1.
     - Next state MD_BUSY; counter loads (md_is_div ? DIV_LAT : MULT_LAT) - 1.
     - branch_taken is ignored in this cycle; the combination is an illegal encoding.
  2. Taken branch: branch_taken=1.
     - Outputs: fd_flush=1, dx_flush=1, pc_en=1.
     - Any load-use match in the same cycle is discarded, because that instruction is being flushed.
  3. Load-use: dx_is_load=1, dx_rd is not 0, and either (fd_uses_rs and fd_rs==dx_rd) or (fd_uses_rt and fd_rt==dx_rd).
     - Outputs: pc_en=0, fd_en=0, dx_flush=1. xm_en and mw_en stay 1.
     - Exactly one bubble is inserted; the next cycle re-evaluates with the nop now in D/X.
- MD_BUSY:
  - Outputs: pc_en=fd_en=dx_en=0, xm_flush=1, md_busy=1. mw_en stays 1 so older instructions drain.
  - If counter==1, next state is MD_DONE; otherwise the counter decrements.
  - All hazard inputs are ignored.
- MD_DONE (one cycle):
  - Outputs: all enables 1, no flushes, md_busy=0, md_start=0.
  - X/M captures the result and the pipeline advances. dx_is_md is ignored so the same instruction cannot re-trigger.
  - Next state is RUN.
- Mult/div timing:
  - The front end is frozen for exactly LAT cycles: the start cycle plus LAT-1 MD_BUSY cycles.
  - MD_DONE occurs LAT cycles after the md_start cycle.
  - A back-to-back mult/div sees dx_is_md again in RUN and restarts normally.
- stall_cycles: increments on each rising edge where clr=0 and pc_en=0; saturates at all ones and does not wrap.
- Reset asserted mid-MD_BUSY: the state machine aborts to RUN immediately and md_busy drops asynchronously.

Test Plan:
- Reset and idle: assert clr, then release with all inputs 0 → all enables 1, all flushes 0, stall_cycles=0, held for 10 cycles.
- Load-use stall:
  - dx_is_load=1, dx_rd=5, fd_rs=5, fd_uses_rs=1 for one cycle → pc_en=fd_en=0, dx_flush=1 for exactly 1 cycle; stall_cycles=1.
  - Repeat with dx_rd=0 → no stall.
- Branch versus load-use: branch_taken=1 together with a load-use match → fd_flush=dx_flush=1, pc_en=1, stall_cycles unchanged.
- Mult: dx_is_md=1, md_is_div=0 → md_start high for 1 cycle, front end frozen 32 cycles, MD_DONE 32 cycles after start, stall_cycles=32.
- Div, then an immediate second mult: div freezes the front end 33 cycles and the following mult freezes it 32 cycles → stall_cycles=65 and exactly two md_start pulses.
- clr pulsed at cycle 10 of a mult → md_busy drops asynchronously, enables 0 during clr, state RUN after release, stall_cycles=0.
